// File: rtl/gelato_ibuffer_queue_pkg.sv
// Shared types for the instruction buffer between I-Decode and Issue.
// Holds the default payload types, the per-warp entry record and the
// default buffer depth.
package gelato_ibuffer_queue_pkg;

  localparam int ADDR_W_DEF  = 32;
  localparam int THREADS_DEF = 32;
  localparam int INST_W      = 32;
  localparam int IBUF_DEPTH  = 4;

  typedef logic [ADDR_W_DEF-1:0]  addr_t;
  typedef logic [THREADS_DEF-1:0] thread_mask_t;
  typedef logic [INST_W-1:0]      inst_t;

  // warp_num is not stored: it is implied by which per-warp queue holds it
  typedef struct packed {
    addr_t        pc;
    thread_mask_t thread_mask;
    inst_t        inst;
  } ibuf_entry_t;

endpackage

// File: rtl/gelato_ibuffer_warp_fifo.sv
// One per-warp synchronous FIFO of instruction-buffer entries.
// Ports: clk/rst (sync, active-high), push/push_data, pop, flush (clears
// the queue and wins over a same-cycle push/pop), head (entry at the read
// pointer), count/full/empty derived from registered state.
module gelato_ibuffer_warp_fifo
  import gelato_ibuffer_queue_pkg::*;
#(
  parameter int  DEPTH   = IBUF_DEPTH,
  parameter type entry_t = ibuf_entry_t,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  entry_t           push_data,
  input  logic             pop,
  input  logic             flush,
  output entry_t           head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  entry_t [DEPTH-1:0] mem_q, mem_d;
  logic   [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic   [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic   [CNT_W-1:0] count_q, count_d;
  logic               do_push, do_pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    do_push  = push && !full;
    do_pop   = pop && !empty;
    if (flush) begin
      // flush drops any same-cycle push; stale data in mem is harmless
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/gelato_ibuffer_queue.sv
// Instruction buffer between I-Decode and Issue: one FIFO per warp,
// ready backpressure on the decode side, per-warp flush and round-robin
// issue selection among non-empty, non-stalled, non-flushed warps.
// Ports: in_* decode hand-off (in_ready = target warp not full),
// stall_mask, flush_valid/flush_warp_num, out_* issue hand-off,
// full_mask/empty_mask/count_o per-warp status from registered state.
module gelato_ibuffer_queue
  import gelato_ibuffer_queue_pkg::*;
#(
  parameter int  NUM_WARPS = 4,
  parameter int  DEPTH     = IBUF_DEPTH,
  parameter int  ADDR_W    = 32,
  parameter int  THREADS   = 32,
  localparam int WARP_W    = $clog2(NUM_WARPS),
  localparam int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ADDR_W-1:0]          in_pc,
  input  logic [WARP_W-1:0]          in_warp_num,
  input  logic [THREADS-1:0]         in_thread_mask,
  input  inst_t                      in_inst,
  input  logic [NUM_WARPS-1:0]       stall_mask,
  input  logic                       flush_valid,
  input  logic [WARP_W-1:0]          flush_warp_num,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ADDR_W-1:0]          out_pc,
  output logic [WARP_W-1:0]          out_warp_num,
  output logic [THREADS-1:0]         out_thread_mask,
  output inst_t                      out_inst,
  output logic [NUM_WARPS-1:0]       full_mask,
  output logic [NUM_WARPS-1:0]       empty_mask,
  output logic [NUM_WARPS*CNT_W-1:0] count_o
);

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [THREADS-1:0] thread_mask;
    inst_t              inst;
  } entry_t;

  entry_t                 push_data;
  entry_t                 head [NUM_WARPS];
  logic [CNT_W-1:0]       cnt  [NUM_WARPS];
  logic [NUM_WARPS-1:0]   push, pop, flush, elig;
  logic [WARP_W-1:0]      rr_q, rr_d;
  logic [WARP_W-1:0]      winner, idx;
  logic                   sel_valid;

  assign push_data = '{pc: in_pc, thread_mask: in_thread_mask, inst: in_inst};
  // No pass-through: a full warp refuses input even if it pops this cycle
  assign in_ready  = !full_mask[in_warp_num];

  for (genvar g = 0; g < NUM_WARPS; g++) begin : g_warp
    assign push[g]  = in_valid && in_ready && (in_warp_num == WARP_W'(g));
    assign flush[g] = flush_valid && (flush_warp_num == WARP_W'(g));
    assign elig[g]  = !empty_mask[g] && !stall_mask[g] && !flush[g];
    assign pop[g]   = sel_valid && out_ready && (winner == WARP_W'(g));
    assign count_o[g*CNT_W +: CNT_W] = cnt[g];

    gelato_ibuffer_warp_fifo #(
      .DEPTH   (DEPTH),
      .entry_t (entry_t)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push[g]),
      .push_data (push_data),
      .pop       (pop[g]),
      .flush     (flush[g]),
      .head      (head[g]),
      .count     (cnt[g]),
      .full      (full_mask[g]),
      .empty     (empty_mask[g])
    );
  end

  // Round-robin: first eligible warp scanning upward from rr_q; the
  // power-of-two warp count makes the index addition wrap on its own.
  always_comb begin
    sel_valid = 1'b0;
    winner    = '0;
    idx       = '0;
    for (int k = 0; k < NUM_WARPS; k++) begin
      idx = rr_q + WARP_W'(k);
      if (!sel_valid && elig[idx]) begin
        sel_valid = 1'b1;
        winner    = idx;
      end
    end
  end

  always_comb begin
    out_valid       = sel_valid;
    out_warp_num    = '0;
    out_pc          = '0;
    out_thread_mask = '0;
    out_inst        = '0;
    if (sel_valid) begin
      out_warp_num    = winner;
      out_pc          = head[winner].pc;
      out_thread_mask = head[winner].thread_mask;
      out_inst        = head[winner].inst;
    end
  end

  assign rr_d = (sel_valid && out_ready) ? winner + WARP_W'(1) : rr_q;

  always_ff @(posedge clk) begin
    if (rst) rr_q <= '0;
    else     rr_q <= rr_d;
  end

endmodule

// File: doc/gelato_ibuffer_queue.md
Name: gelato_ibuffer_queue

Overview:
Parametrised instruction buffer between I-Decode and Issue. It replaces the single-entry, no-backpressure decode→buffer hand-off with one FIFO per warp. It adds ready backpressure, per-warp flush and round-robin selection among non-stalled warps. It carries the same payload as the existing hand-off: pc, warp_num, thread_mask and inst_t.

Parameters:
NUM_WARPS, 4, number of warps (power of two, ≥2); WARP_W = $clog2(NUM_WARPS)
DEPTH, 4, entries per warp FIFO (power of two, ≥2); CNT_W = $clog2(DEPTH+1)
ADDR_W, 32, pc width (addr_t)
THREADS, 32, thread_mask width (thread_mask_t)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  decoded instruction offered
in_ready  out  1  queue for in_warp_num can accept
in_pc  in  ADDR_W  instruction pc
in_warp_num  in  WARP_W  target warp
in_thread_mask  in  THREADS  active threads
in_inst  in  $bits(inst_t)  decoded instruction
stall_mask  in  NUM_WARPS  warp i ineligible for issue (scoreboard/barrier)
flush_valid  in  1  discard all entries of flush_warp_num
flush_warp_num  in  WARP_W  warp to flush
out_valid  out  1  selected head instruction valid
out_ready  in  1  issue accepts
out_pc, out_warp_num, out_thread_mask, out_inst  out  as inputs  selected head payload
full_mask  out  NUM_WARPS  per-warp FIFO full
empty_mask  out  NUM_WARPS  per-warp FIFO empty
count_o  out  NUM_WARPS*CNT_W  per-warp occupancy, warp i at bits [i*CNT_W +: CNT_W]

Behaviour:
- One clock (clk); reset synchronous, active-high (rst). All state updates on posedge clk.
- Reset: all FIFOs empty, pointers 0, RR pointer 0.
- Reset outputs: out_valid=0, in_ready=1, full_mask=0, empty_mask=all 1, count_o=0. out_* payload=0 when out_valid=0.
- Storage per warp: circular buffer with rd/wr pointers of $clog2(DEPTH) bits, wrapping DEPTH-1→0. Count is CNT_W bits; full when count==DEPTH.
- Enqueue:
  - in_ready = !full[in_warp_num], combinational. There is no pass-through when full, even if the same warp is popped in that cycle.
  - Handshake fires when in_valid && in_ready. The entry is written at the wr pointer and the count increments.
  - An enqueued entry becomes visible at the output the next cycle at the earliest; there is no same-cycle bypass.
- Eligibility: warp i is eligible when !empty[i] && !stall_mask[i] && !(flush_valid && flush_warp_num==i).
- Selection:
  - Combinational round-robin. The winner is the first eligible warp scanning from the RR pointer upward, modulo NUM_WARPS.
  - out_valid = any eligible. out_* is the head entry of the winner; out_warp_num equals the winner index.
- Dequeue:
  - On out_valid && out_ready, the winner's rd pointer advances and its count decrements.
  - The RR pointer becomes winner+1 mod NUM_WARPS.
  - Without a handshake, the RR pointer holds.
  - out_valid/payload may change while out_ready is low, because selection is not sticky. Issue must sample on the handshake only.
- Simultaneous events on the same warp:
  - enq+deq (not full): count unchanged, both pointers advance.
  - flush+enq: flush wins. Count→0, pointers reset to 0, the incoming entry is dropped. in_ready still reflects full, so the producer sees acceptance; software flushes only on redirect.
  - flush+deq: impossible, since a flushed warp is ineligible that cycle.
- Flush of warp A does not disturb other warps, including a same-cycle enqueue/dequeue on warp B.
- Mid-operation reset: all contents are discarded in that cycle. Reset has priority over every other input.
- full_mask, empty_mask and count_o are registered-state derived and reflect the state after the last clock edge.

Decomposition:
- gelato_types gains ibuf_entry_t, a packed struct {addr_t pc; thread_mask_t thread_mask; inst_t inst;}. warp_num is implied by the queue index.
- gelato_types gains the IBUF_DEPTH constant.
- Sub-module gelato_ibuffer_warp_fifo: one synchronous FIFO of ibuf_entry_t with push, pop, flush, count, full and empty. It is instantiated NUM_WARPS times in a generate loop.
- RR select stays inline in gelato_ibuffer_queue.

Test Plan:
- Reset then idle → in_ready=1, out_valid=0, empty_mask=4'b1111, count_o=0.
- Fill warp 2 with 4 entries (pc 0x100..0x10C), out_ready=0 → full_mask=4'b0100, in_ready=0 for warp 2 and 1 for warp 0. A 5th push to warp 2 is not accepted.
- Warps 0,1,3 each hold one entry, out_ready=1 constantly → issue order 0,1,3. The RR pointer wraps so the next entry pushed to warp 0 issues after warp 3.
- stall_mask=4'b0001 with warps 0 and 1 non-empty → warp 1 issues. After stall clears, warp 0 issues next.
- Warp 1 holds 3 entries; flush_valid on warp 1 in the same cycle as a push to warp 1 and a pop from warp 3 → warp 1 count=0, pushed entry dropped, warp 3 count decremented by 1.
- Push 3 entries to warp 0 and assert rst on the third push → next cycle all empty, out_valid=0, count_o=0.
